front_end_mp: RTL
=================

# front_end_mp

Multi-port front end for the iob cache. It replaces the single-requester front end when several masters share one cache, for example CPU instruction and data buses or a DMA. It takes N_PORTS native-interface requesters and arbitrates between them round-robin. The winning request is registered and held toward the cache data path or the cache-control unit until that side answers. The response is then routed back to the granted port only.

## Interface
- FE_ADDR_W, 32: byte-address width seen by the cache.
- FE_DATA_W, 32: word width.
- FE_NBYTES, FE_DATA_W/8: bytes per word (derived).
- FE_BYTE_W, $clog2(FE_NBYTES): byte-offset width (derived).
- N_PORTS, 2: number of requester ports (1..8).
- CTRL_CACHE, 0: 1 means address MSB selects cache-control; 0 means no control path.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid  in  N_PORTS  per-port request; held high until that port's ready.
- addr  in  N_PORTS*(CTRL_CACHE+FE_ADDR_W)  flattened per-port byte address; port p occupies slice p.
- wdata  in  N_PORTS*FE_DATA_W  flattened write data.
- wstrb  in  N_PORTS*FE_NBYTES  flattened byte strobes; all zero means read.
- ready  out  N_PORTS  one-cycle per-port completion.
- rdata  out  N_PORTS*FE_DATA_W  per-port read data, valid with ready.
- grant  out  $clog2(N_PORTS) (min 1)  index of the port currently being served.
- busy  out  1  a request is in flight.
- data_valid  out  1  request to cache data path.
- data_addr  out  FE_ADDR_W-FE_BYTE_W  word address of held request.
- data_wdata  out  FE_DATA_W  write data of held request.
- data_wstrb  out  FE_NBYTES  strobes of held request.
- data_rdata  in  FE_DATA_W  cache read data.
- data_ready  in  1  cache completion.
- ctrl_valid  out  1  request to cache-control.
- ctrl_addr  out  `CTRL_ADDR_W  control register address.
- ctrl_rdata  in  FE_DATA_W  control read data.
- ctrl_ready  in  1  control completion.

## Operation
- FSM states: IDLE and BUSY.
- IDLE: the arbiter searches from pointer ptr upward, modulo N_PORTS, for the first port with valid=1.
- On a winner p: latch addr, wdata and wstrb of p into the held registers, set grant=p, set sel_ctrl=CTRL_CACHE ? addr_p[MSB] : 0, and go to BUSY.
- BUSY: drive data_valid=~sel_ctrl and ctrl_valid=sel_ctrl.
  - data_addr = held addr[FE_ADDR_W-1:FE_BYTE_W].
  - ctrl_addr = held addr[FE_BYTE_W +: `CTRL_ADDR_W].
  - data_wdata and data_wstrb come from the held registers.
- Completion: in BUSY, the selected-side ready (data_ready if ~sel_ctrl, else ctrl_ready) completes the request.
  - Assert ready[grant]=1 combinationally in the same cycle.
  - rdata slice grant = selected-side rdata.
  - Set ptr to (grant+1) mod N_PORTS and return to IDLE.
- The ready of the non-selected side is ignored while BUSY. Both readies are ignored while IDLE.
- rdata slices of non-granted ports, and all slices when ready is 0, are driven 0.
- With CTRL_CACHE=0: ctrl_valid=0, ctrl_addr=0, and the address MSB logic is absent.
- With N_PORTS=1: grant is constant 0 and ptr is unused.
- The arbiter never preempts. A port that drops valid before its ready is a protocol violation; its latched request still completes.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, ptr=0, grant=0, busy=0, data_valid=0, ctrl_valid=0, data_addr=0, data_wdata=0, data_wstrb=0, ctrl_addr=0, all ready=0, all rdata=0.
- Reset asserted mid-request: the request is dropped and no ready is issued. After release, the still-asserted valid is re-arbitrated from ptr=0.
- Acceptance: a valid seen in IDLE at edge n puts the request on data_valid or ctrl_valid from cycle n+1.
- Latency: ready[p] arrives in the same cycle as the cache ready, at the earliest 1 cycle after acceptance. The minimum round trip is 2 cycles from valid to ready.
- Back-to-back: IDLE is spent for exactly one cycle between requests. Maximum throughput is one request per 2 cycles plus the cache latency.
- Fairness: any continuously asserted valid is served within N_PORTS grants.
- busy = (state==BUSY).

## Test plan
- Single read, N_PORTS=2, CTRL_CACHE=0: port0 reads addr 0x48d0; cache answers data_ready with 0xDEADBEEF 3 cycles later. Expected: data_addr=0x1234, then ready=2'b01 and port0 rdata=0xDEADBEEF in the same cycle; port1 rdata=0.
- Contention: ports 0 and 1 both valid from reset release, with writes of 0xCAFEEFAC and 0x01020304. Expected: port0 is served first and port1 second; the next grant goes to port0 if still valid. No cycle has both ready bits set.
- Fairness, N_PORTS=4: all valid continuously with an immediate cache ready. Expected: grant sequence 0,1,2,3,0,… with ready pulses every 2 cycles.
- Control path, CTRL_CACHE=1: port1 sets address MSB=1. Expected: ctrl_valid=1 and data_valid=0; a data_ready pulse is ignored; ctrl_ready with 0x5 produces ready[1]=1 with rdata=0x5.
- Write strobes: port0 writes wstrb=4'b0101, wdata=0xF1E2D3C4. Expected: data_wstrb=4'b0101 and data_wdata=0xF1E2D3C4, held stable until data_ready.
- Reset mid-op: assert reset while BUSY. Expected: all outputs go to reset values immediately; after release, the pending valid is re-accepted and completes normally.

Source files
------------

// File: rtl/front_end_mp.sv
// Multi-port front end for the iob cache: round-robin arbitration over N_PORTS
// native requesters, one registered request held toward the data or control path.
`ifndef CTRL_ADDR_W
`define CTRL_ADDR_W 4
`endif

module front_end_mp #(
    parameter int FE_ADDR_W  = 32,
    parameter int FE_DATA_W  = 32,
    parameter int FE_NBYTES  = FE_DATA_W / 8,
    parameter int FE_BYTE_W  = $clog2(FE_NBYTES),
    parameter int N_PORTS    = 2,
    parameter int CTRL_CACHE = 0
) (
    input  logic                                        clk_i,
    input  logic                                        rst_n_i,
    input  logic [N_PORTS-1:0]                          valid_i,
    input  logic [N_PORTS*(CTRL_CACHE+FE_ADDR_W)-1:0]   addr_i,
    input  logic [N_PORTS*FE_DATA_W-1:0]                wdata_i,
    input  logic [N_PORTS*FE_NBYTES-1:0]                wstrb_i,
    output logic [N_PORTS-1:0]                          ready_o,
    output logic [N_PORTS*FE_DATA_W-1:0]                rdata_o,
    output logic [((N_PORTS > 1) ? $clog2(N_PORTS) : 1)-1:0] grant_o,
    output logic                                        busy_o,
    output logic                                        data_valid_o,
    output logic [FE_ADDR_W-FE_BYTE_W-1:0]              data_addr_o,
    output logic [FE_DATA_W-1:0]                        data_wdata_o,
    output logic [FE_NBYTES-1:0]                        data_wstrb_o,
    input  logic [FE_DATA_W-1:0]                        data_rdata_i,
    input  logic                                        data_ready_i,
    output logic                                        ctrl_valid_o,
    output logic [`CTRL_ADDR_W-1:0]                     ctrl_addr_o,
    input  logic [FE_DATA_W-1:0]                        ctrl_rdata_i,
    input  logic                                        ctrl_ready_i
);
    localparam int GW  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int AW  = CTRL_CACHE + FE_ADDR_W;
    localparam int CAW = `CTRL_ADDR_W;

    typedef enum logic {IDLE, BUSY} state_t;

    logic [N_PORTS-1:0][AW-1:0]        addr_v;
    logic [N_PORTS-1:0][FE_DATA_W-1:0] wdata_v;
    logic [N_PORTS-1:0][FE_NBYTES-1:0] wstrb_v;
    logic [N_PORTS-1:0][FE_DATA_W-1:0] rdata_v;

    assign addr_v  = addr_i;
    assign wdata_v = wdata_i;
    assign wstrb_v = wstrb_i;
    assign rdata_o = rdata_v;

    state_t                 state_q, state_d;
    logic [GW-1:0]          ptr_q, ptr_d, grant_q, grant_d;
    logic                   sel_q, sel_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [FE_DATA_W-1:0]   wdata_q, wdata_d;
    logic [FE_NBYTES-1:0]   wstrb_q, wstrb_d;

    logic                   win_found, done;
    logic [GW-1:0]          win_idx, ptr_inc;
    logic [GW:0]            cand, ptr_sum;
    logic [FE_DATA_W-1:0]   resp;

    // Rotating search: first valid port at or above ptr, wrapping at N_PORTS.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            cand = {1'b0, ptr_q} + (GW+1)'(i);
            if (cand >= (GW+1)'(N_PORTS)) cand = cand - (GW+1)'(N_PORTS);
            if (!win_found && valid_i[cand[GW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[GW-1:0];
            end
        end
    end

    assign ptr_sum = {1'b0, grant_q} + (GW+1)'(1);
    assign ptr_inc = (ptr_sum >= (GW+1)'(N_PORTS)) ? '0 : ptr_sum[GW-1:0];
    assign done    = (state_q == BUSY) && (sel_q ? ctrl_ready_i : data_ready_i);
    assign resp    = sel_q ? ctrl_rdata_i : data_rdata_i;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        case (state_q)
            IDLE: if (win_found) begin
                state_d = BUSY;
                grant_d = win_idx;
                addr_d  = addr_v[win_idx];
                wdata_d = wdata_v[win_idx];
                wstrb_d = wstrb_v[win_idx];
                sel_d   = (CTRL_CACHE != 0) ? addr_v[win_idx][AW-1] : 1'b0;
            end
            BUSY: if (done) begin
                state_d = IDLE;
                ptr_d   = ptr_inc;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    // Completion is steered only to the granted port; every other slice stays 0.
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            ready_o[p] = done && (grant_q == GW'(p));
            rdata_v[p] = ready_o[p] ? resp : '0;
        end
    end

    assign grant_o      = grant_q;
    assign busy_o       = (state_q == BUSY);
    assign data_valid_o = busy_o && !sel_q;
    assign ctrl_valid_o = busy_o && sel_q;
    assign data_addr_o  = addr_q[FE_ADDR_W-1:FE_BYTE_W];
    assign data_wdata_o = wdata_q;
    assign data_wstrb_o = wstrb_q;

    generate
        if (CTRL_CACHE != 0) begin : g_ctrl
            assign ctrl_addr_o = addr_q[FE_BYTE_W +: CAW];
        end else begin : g_noctrl
            assign ctrl_addr_o = '0;
        end
    endgenerate

    logic unused_addr;
    assign unused_addr = ^addr_q;
endmodule
